// File: rtl/obj_ram_writer.sv
// Sprite object RAM loader: bottom-aligns a bitmap into one object slot, zero-filling the rows above it.
// Latency: one write per cycle (clear or accepted row); rd_data is registered, valid one cycle after rd_en.
// Backpressure: cmd_ready only while idle, row_ready only while loading; the renderer read port never stalls.
module obj_ram_writer #(
    parameter int NUM_OBJ    = 4,
    parameter int MAX_SIZE_Y = 64,
    parameter int MAX_SIZE_X = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [$clog2(NUM_OBJ)-1:0]    cmd_obj,
    input  logic [$clog2(MAX_SIZE_Y):0]   cmd_rows,
    input  logic                          row_valid,
    output logic                          row_ready,
    input  logic [MAX_SIZE_X-1:0]         row_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    input  logic                          rd_en,
    input  logic [$clog2(NUM_OBJ)-1:0]    rd_obj,
    input  logic [$clog2(MAX_SIZE_Y)-1:0] rd_row,
    output logic [MAX_SIZE_X-1:0]         rd_data
);

    localparam int OW    = $clog2(NUM_OBJ);
    localparam int YW    = $clog2(MAX_SIZE_Y);
    localparam int RW    = YW + 1;
    localparam int DEPTH = NUM_OBJ * MAX_SIZE_Y;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [RW-1:0] YMAX = RW'(MAX_SIZE_Y);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]            state;
    logic [OW-1:0]         cur_obj;
    logic [RW-1:0]         cur_rows;
    logic [RW-1:0]         ptr;
    logic                  cmd_obj_ok;
    logic                  rd_obj_ok;
    logic                  cmd_ok;
    logic                  clear_last;
    logic                  wr_en;
    logic [MAX_SIZE_X-1:0] wr_data;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;

    logic [MAX_SIZE_X-1:0] mem [DEPTH];

    function automatic logic [AW-1:0] addr_of(input logic [OW-1:0] o, input logic [YW-1:0] r);
        return AW'(o) * AW'(MAX_SIZE_Y) + AW'(r);
    endfunction

    // With a power-of-two object count every index encoding is a real slot.
    if (NUM_OBJ == (1 << OW)) begin : g_obj_full
        assign cmd_obj_ok = 1'b1;
        assign rd_obj_ok  = 1'b1;
    end else begin : g_obj_part
        assign cmd_obj_ok = (int'(cmd_obj) < NUM_OBJ);
        assign rd_obj_ok  = (int'(rd_obj) < NUM_OBJ);
    end

    assign cmd_ok     = cmd_obj_ok && (cmd_rows != '0) && (cmd_rows <= YMAX);
    assign clear_last = (ptr == YMAX - cur_rows - RW'(1));

    assign cmd_ready = (state == ST_IDLE);
    assign row_ready = (state == ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (state)
            ST_CLEAR: wr_en = 1'b1;
            ST_LOAD: begin
                wr_en   = row_valid;
                wr_data = row_data;
            end
            default: wr_en = 1'b0;
        endcase
        // Reset wins over any in-flight handshake, and the pointer never addresses past the slot.
        if (rst || (ptr >= YMAX)) begin
            wr_en = 1'b0;
        end
    end

    assign wr_addr = addr_of(cur_obj, ptr[YW-1:0]);
    assign rd_addr = addr_of(rd_obj, rd_row);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_obj  <= '0;
            cur_rows <= '0;
            ptr      <= '0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_ok) begin
                            cur_obj  <= cmd_obj;
                            cur_rows <= cmd_rows;
                            ptr      <= '0;
                            state    <= (cmd_rows == YMAX) ? ST_LOAD : ST_CLEAR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    ptr <= ptr + RW'(1);
                    if (clear_last) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (row_valid) begin
                        ptr <= ptr + RW'(1);
                        if (ptr == YMAX - RW'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately left out of reset so an aborted load keeps what it already wrote.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_obj_ok ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: doc/obj_ram_writer.md
OBJ_RAM_WRITER -- requirements
Module: obj_ram_writer

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 4, number of sprite objects.
REQ-002 SHALL have parameter MAX_SIZE_Y, default 64, rows per object slot.
REQ-003 SHALL have parameter MAX_SIZE_X, default 16, bits per row.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  in  1  load command valid.
REQ-007 SHALL have port cmd_ready  out  1  load command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_obj  in  $clog2(NUM_OBJ)  target object index.
REQ-009 SHALL have port cmd_rows  in  $clog2(MAX_SIZE_Y)+1  bitmap height in rows.
REQ-010 SHALL have port row_valid  in  1  row data valid.
REQ-011 SHALL have port row_ready  out  1  row data accepted when high with row_valid.
REQ-012 SHALL have port row_data  in  MAX_SIZE_X  one bitmap row, MSB = leftmost pixel.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse when a load completes.
REQ-015 SHALL have port err  out  1  one-cycle pulse when a command is rejected.
REQ-016 SHALL have port rd_en  in  1  renderer read strobe.
REQ-017 SHALL have port rd_obj  in  $clog2(NUM_OBJ)  read object index.
REQ-018 SHALL have port rd_row  in  $clog2(MAX_SIZE_Y)  read row index.
REQ-019 SHALL have port rd_data  out  MAX_SIZE_X  registered row read data.

Function
REQ-020 SHALL hold storage NUM_OBJ x MAX_SIZE_Y x MAX_SIZE_X bits, one write port, one read port.
REQ-021 SHALL implement FSM states IDLE, CLEAR, LOAD, DONE.
REQ-022 SHALL drive cmd_ready=1 only in IDLE; row_ready=1 only in LOAD.
REQ-023 In IDLE on cmd handshake with cmd_rows in 1..MAX_SIZE_Y and cmd_obj < NUM_OBJ, SHALL latch obj/rows, set row pointer to 0, go to CLEAR (or LOAD if cmd_rows == MAX_SIZE_Y).
REQ-024 In IDLE on cmd handshake with cmd_rows == 0, cmd_rows > MAX_SIZE_Y or cmd_obj >= NUM_OBJ, SHALL pulse err next cycle, write nothing, stay IDLE.
REQ-025 CLEAR SHALL write zero to rows 0..MAX_SIZE_Y-rows-1 of the object, one row per cycle, then enter LOAD with pointer = MAX_SIZE_Y-rows (bitmaps bottom-aligned).
REQ-026 LOAD SHALL write row_data to the pointed row on each row handshake and increment pointer; no write on cycles without handshake.
REQ-027 After the handshake writing row MAX_SIZE_Y-1, SHALL enter DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 cmd_valid outside IDLE SHALL be ignored (not accepted, no err).
REQ-029 rd_data SHALL update one cycle after rd_en high with mem[rd_obj][rd_row]; SHALL hold value when rd_en low.
REQ-030 Read and write same address same cycle SHALL return old (pre-write) data.
REQ-031 Read of out-of-range rd_obj SHALL return all zeros.
REQ-032 Pointer arithmetic SHALL not wrap; no write beyond row MAX_SIZE_Y-1.

Reset
REQ-033 On rst, SHALL enter IDLE; cmd_ready=1, row_ready=0, busy=0, done=0, err=0, rd_data=0.
REQ-034 rst mid-CLEAR/LOAD SHALL abort load; rows already written retain values; memory not cleared by reset.
REQ-035 rst SHALL take priority over all handshakes in the same cycle.

Verification
REQ-036 cmd obj=2 rows=64, 64 rows 0x0000..0x003F back-to-back -> no CLEAR, done pulse after 64th row, rd obj2 row 5 = 0x0005.
REQ-037 cmd obj=0 rows=16 -> 48 CLEAR cycles, 16 rows 0xFFFF -> rows 0..47 read 0x0000, rows 48..63 read 0xFFFF.
REQ-038 cmd rows=0, then rows=65 -> err pulse each, cmd_ready stays 1, memory unchanged.
REQ-039 row_valid toggling every other cycle during LOAD of 4 rows -> exactly 4 writes, done once.
REQ-040 rst asserted after 3 of 16 rows -> IDLE next cycle, busy=0, the 3 written rows readable, no done.
REQ-041 rd_en to row being written same cycle -> rd_data = old value, next read = new value.
